// File: rtl/arf_rat.sv
// arf_rat: architectural register file plus register alias table.
// On dispatch, it records which ROB entry will produce each destination.
// On retire, it commits data and drops the alias if the retiring tag still
// owns the register. A flush (redirect) drops every alias.
// Source lookups are combinational from the registered state.
// Optional feature macro: ARF_RETIRE_BYPASS_EN. When it is defined, a retire
// that clears a source's alias is forwarded to that source's lookup in the
// same cycle.
//
// Handshake: a dispatch takes effect only when dispatch_valid and
// dispatch_ready are both high at a posedge. dispatch_ready is owned by the
// ROB, and this block never stalls it. Retire has no handshake and is always
// accepted.
module arf_rat #(
  parameter  int ARF_N_ENTRIES  = 32,
  parameter  int ROB_N_ENTRIES  = 8,
  parameter  int REG_DATA_WIDTH = 32,
  localparam int ARF_ID_WIDTH   = $clog2(ARF_N_ENTRIES),
  localparam int ROB_ID_WIDTH   = $clog2(ROB_N_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dispatch_valid,
  input  logic                      dispatch_ready,
  input  logic                      dispatch_dst_valid,
  input  logic [ARF_ID_WIDTH-1:0]   dispatch_dst_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
  input  logic [ARF_ID_WIDTH-1:0]   src1_arf_id,
  input  logic [ARF_ID_WIDTH-1:0]   src2_arf_id,
  output logic                      src1_in_rob,
  output logic                      src2_in_rob,
  output logic [ROB_ID_WIDTH-1:0]   src1_rob_id,
  output logic [ROB_ID_WIDTH-1:0]   src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_arf_data,
  output logic [REG_DATA_WIDTH-1:0] src2_arf_data,
  input  logic                      retire,
  input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  input  logic [ARF_ID_WIDTH-1:0]   retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      retire_redirect_pc_valid,
  output logic [ARF_N_ENTRIES-1:0]  busy_vec
);

  logic [ARF_N_ENTRIES-1:0]  r_busy;
  logic [ROB_ID_WIDTH-1:0]   r_tag  [ARF_N_ENTRIES];
  logic [REG_DATA_WIDTH-1:0] r_data [ARF_N_ENTRIES];

  logic w_dispatch_set;
  logic w_retire_wr;
  logic w_retire_clr;

  // x0 is never renamed or written, so busy[0] stays 0 forever.
  assign w_dispatch_set = dispatch_valid & dispatch_ready & dispatch_dst_valid &
                          (dispatch_dst_arf_id != '0);
  assign w_retire_wr    = retire & (retire_arf_id != '0);
  // Clear the alias only when the retiring entry is still the newest producer.
  assign w_retire_clr   = w_retire_wr & r_busy[retire_arf_id] &
                          (r_tag[retire_arf_id] == retire_rob_id);

  assign busy_vec = r_busy;

  // Alias-valid bits. Priority is flush, then dispatch set, then retire clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (retire_redirect_pc_valid) begin
      r_busy <= '0;
    end else begin
      if (w_retire_clr) r_busy[retire_arf_id] <= 1'b0;
      // A later nonblocking write wins, so a dispatch overrides a same-register clear.
      if (w_dispatch_set) r_busy[dispatch_dst_arf_id] <= 1'b1;
    end
  end

  // Producer tags. A dispatch that is squashed by a flush does not update its tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_N_ENTRIES; i++) r_tag[i] <= '0;
    end else if (w_dispatch_set && !retire_redirect_pc_valid) begin
      r_tag[dispatch_dst_arf_id] <= dispatch_rob_id;
    end
  end

  // Committed data. A retire always writes, even during a flush or a dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_N_ENTRIES; i++) r_data[i] <= '0;
    end else if (w_retire_wr) begin
      r_data[retire_arf_id] <= retire_reg_data;
    end
  end

  // Source 1 lookup: the registered alias or committed value, with x0 forced to zero.
  always_comb begin
    src1_in_rob   = r_busy[src1_arf_id];
    src1_rob_id   = r_busy[src1_arf_id] ? r_tag[src1_arf_id] : '0;
    src1_arf_data = r_data[src1_arf_id];
    if (src1_arf_id == '0) begin
      src1_in_rob   = 1'b0;
      src1_rob_id   = '0;
      src1_arf_data = '0;
    end
`ifdef ARF_RETIRE_BYPASS_EN
    if (w_retire_clr && (retire_arf_id == src1_arf_id)) begin
      src1_in_rob   = 1'b0;
      src1_rob_id   = '0;
      src1_arf_data = retire_reg_data;
    end
`endif
  end

  // Source 2 lookup: the same as source 1, but on its own id.
  always_comb begin
    src2_in_rob   = r_busy[src2_arf_id];
    src2_rob_id   = r_busy[src2_arf_id] ? r_tag[src2_arf_id] : '0;
    src2_arf_data = r_data[src2_arf_id];
    if (src2_arf_id == '0) begin
      src2_in_rob   = 1'b0;
      src2_rob_id   = '0;
      src2_arf_data = '0;
    end
`ifdef ARF_RETIRE_BYPASS_EN
    if (w_retire_clr && (retire_arf_id == src2_arf_id)) begin
      src2_in_rob   = 1'b0;
      src2_rob_id   = '0;
      src2_arf_data = retire_reg_data;
    end
`endif
  end

endmodule

// File: tb/tb_arf_rat.sv
// tb_arf_rat: directed steps followed by randomized traffic for arf_rat.
// Expected values come from a register-level model of the alias table.
module tb_arf_rat;

  logic        clk = 1'b0;
  logic        rst;
  logic        dispatch_valid, dispatch_ready, dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [2:0]  dispatch_rob_id;
  logic [4:0]  src1_arf_id, src2_arf_id;
  logic        src1_in_rob, src2_in_rob;
  logic [2:0]  src1_rob_id, src2_rob_id;
  logic [31:0] src1_arf_data, src2_arf_data;
  logic        retire;
  logic [2:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        retire_redirect_pc_valid;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  // Model state: one record per architectural register.
  logic        m_busy [32];
  logic [2:0]  m_tag  [32];
  logic [31:0] m_data [32];

  arf_rat dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_dst_valid(dispatch_dst_valid), .dispatch_dst_arf_id(dispatch_dst_arf_id),
    .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src2_arf_id(src2_arf_id),
    .src1_in_rob(src1_in_rob), .src2_in_rob(src2_in_rob),
    .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
    .src1_arf_data(src1_arf_data), .src2_arf_data(src2_arf_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data),
    .retire_redirect_pc_valid(retire_redirect_pc_valid),
    .busy_vec(busy_vec)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dispatch_valid = 0; dispatch_ready = 1; dispatch_dst_valid = 0;
    dispatch_dst_arf_id = 0; dispatch_rob_id = 0;
    retire = 0; retire_rob_id = 0; retire_arf_id = 0; retire_reg_data = 0;
    retire_redirect_pc_valid = 0; rst = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_busy[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
  endtask

  // Apply the effect of the inputs currently driven, as seen at the next edge.
  task automatic model_edge();
    logic fire;
    if (rst) begin
      model_reset();
      return;
    end
    fire = dispatch_valid && dispatch_ready && dispatch_dst_valid && dispatch_dst_arf_id != 0;
    if (retire && retire_arf_id != 0) begin
      if (m_busy[retire_arf_id] && m_tag[retire_arf_id] == retire_rob_id)
        m_busy[retire_arf_id] = 0;
      m_data[retire_arf_id] = retire_reg_data;
    end
    if (retire_redirect_pc_valid) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (fire) begin
      m_busy[dispatch_dst_arf_id] = 1;
      m_tag[dispatch_dst_arf_id]  = dispatch_rob_id;
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic exp_lookup(input logic [4:0] id, output logic e_in,
                            output logic [2:0] e_rob, output logic [31:0] e_data);
    e_in = 0; e_rob = 0; e_data = 0;
    if (id != 0) begin
      e_in   = m_busy[id];
      e_rob  = m_busy[id] ? m_tag[id] : 3'd0;
      e_data = m_data[id];
`ifdef ARF_RETIRE_BYPASS_EN
      if (retire && retire_arf_id == id && m_busy[id] && m_tag[id] == retire_rob_id) begin
        e_in = 0; e_rob = 0; e_data = retire_reg_data;
      end
`endif
    end
  endtask

  // Let the combinational outputs settle, then compare them with the model.
  task automatic check_lookups(input string name);
    logic        e_in;
    logic [2:0]  e_rob;
    logic [31:0] e_data;
    #1;
    exp_lookup(src1_arf_id, e_in, e_rob, e_data);
    chk({name, ".s1_in_rob"}, 32'(src1_in_rob), 32'(e_in));
    chk({name, ".s1_rob_id"}, 32'(src1_rob_id), 32'(e_rob));
    chk({name, ".s1_data"},   src1_arf_data, e_data);
    exp_lookup(src2_arf_id, e_in, e_rob, e_data);
    chk({name, ".s2_in_rob"}, 32'(src2_in_rob), 32'(e_in));
    chk({name, ".s2_rob_id"}, 32'(src2_rob_id), 32'(e_rob));
    chk({name, ".s2_data"},   src2_arf_data, e_data);
    chk({name, ".busy_vec"},  busy_vec, model_busy_vec());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_dispatch(input logic [4:0] dst, input logic [2:0] rob);
    dispatch_valid = 1; dispatch_ready = 1; dispatch_dst_valid = 1;
    dispatch_dst_arf_id = dst; dispatch_rob_id = rob;
  endtask

  task automatic do_retire(input logic [2:0] rob, input logic [4:0] id, input logic [31:0] d);
    retire = 1; retire_rob_id = rob; retire_arf_id = id; retire_reg_data = d;
  endtask

  initial begin
    clear_inputs();
    src1_arf_id = 0; src2_arf_id = 0;
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 1;
    tick();

    // Reset state.
    src1_arf_id = 3; src2_arf_id = 0;
    check_lookups("reset");
    chk("reset.busy_zero", busy_vec, 32'h0);
    chk("reset.x3_data", src1_arf_data, 32'h0);

    // Dispatch x5 with rob 2. The same-cycle lookup must see the old state.
    do_dispatch(5, 2); src1_arf_id = 5; src2_arf_id = 5;
    check_lookups("disp5_same");
    chk("disp5_same.in_rob", 32'(src1_in_rob), 0);
    tick();
    src1_arf_id = 5;
    check_lookups("disp5_next");
    chk("disp5_next.in_rob", 32'(src1_in_rob), 1);
    chk("disp5_next.rob_id", 32'(src1_rob_id), 2);
    do_retire(2, 5, 32'hDEAD); src1_arf_id = 5;
    check_lookups("ret5_same");
`ifdef ARF_RETIRE_BYPASS_EN
    chk("ret5_same.bypass_in_rob", 32'(src1_in_rob), 0);
    chk("ret5_same.bypass_data", src1_arf_data, 32'hDEAD);
`else
    chk("ret5_same.in_rob", 32'(src1_in_rob), 1);
    chk("ret5_same.rob_id", 32'(src1_rob_id), 2);
`endif
    tick();
    src1_arf_id = 5;
    check_lookups("ret5_next");
    chk("ret5_next.data", src1_arf_data, 32'hDEAD);
    chk("ret5_next.in_rob", 32'(src1_in_rob), 0);

    // A younger producer keeps the alias when the older one retires.
    do_dispatch(7, 1); tick();
    do_dispatch(7, 4); tick();
    do_retire(1, 7, 32'h11); tick();
    src1_arf_id = 7;
    check_lookups("x7_old_ret");
    chk("x7_old_ret.data", src1_arf_data, 32'h11);
    chk("x7_old_ret.in_rob", 32'(src1_in_rob), 1);
    chk("x7_old_ret.rob_id", 32'(src1_rob_id), 4);
    do_retire(4, 7, 32'h44); tick();
    src1_arf_id = 7;
    check_lookups("x7_new_ret");
    chk("x7_new_ret.in_rob", 32'(src1_in_rob), 0);

    // A dispatch and a matching retire on the same register in the same cycle.
    do_dispatch(9, 3); tick();
    do_dispatch(9, 6); do_retire(3, 9, 32'h99); tick();
    src1_arf_id = 9;
    check_lookups("x9_same");
    chk("x9_same.in_rob", 32'(src1_in_rob), 1);
    chk("x9_same.rob_id", 32'(src1_rob_id), 6);
    chk("x9_same.data", src1_arf_data, 32'h99);
    do_dispatch(0, 5); tick();
    chk("x0_disp.busy0", 32'(busy_vec[0]), 0);

    // A dispatch without ready is not taken.
    dispatch_valid = 1; dispatch_ready = 0; dispatch_dst_valid = 1;
    dispatch_dst_arf_id = 6; dispatch_rob_id = 7; tick();
    chk("noready.busy6", 32'(busy_vec[6]), 0);

    // A flush together with a dispatch drops every alias, including the new one.
    do_dispatch(4, 1); tick();
    do_dispatch(8, 2); tick();
    do_dispatch(12, 3); tick();
    retire_redirect_pc_valid = 1; do_dispatch(13, 5); tick();
    src1_arf_id = 13; src2_arf_id = 5;
    check_lookups("flush");
    chk("flush.busy_vec", busy_vec, 32'h0);
    chk("flush.x13_in_rob", 32'(src1_in_rob), 0);
    chk("flush.x5_data", src2_arf_data, 32'hDEAD);

    // Retire bypass behaviour.
    do_dispatch(5, 2); tick();
    do_retire(2, 5, 32'h55); src1_arf_id = 5;
    check_lookups("byp");
`ifdef ARF_RETIRE_BYPASS_EN
    chk("byp.in_rob", 32'(src1_in_rob), 0);
    chk("byp.data", src1_arf_data, 32'h55);
`else
    chk("byp.in_rob", 32'(src1_in_rob), 1);
    chk("byp.rob_id", 32'(src1_rob_id), 2);
`endif
    tick();
    src1_arf_id = 5;
    check_lookups("byp_next");
    chk("byp_next.data", src1_arf_data, 32'h55);

    // A reset mid-operation overrides dispatch and retire.
    do_dispatch(3, 1); do_retire(0, 5, 32'h77); rst = 1; tick();
    src1_arf_id = 5; src2_arf_id = 3;
    check_lookups("midrst");
    chk("midrst.busy_vec", busy_vec, 32'h0);
    chk("midrst.x5_data", src1_arf_data, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      dispatch_valid      = ($urandom_range(0, 3) != 0);
      dispatch_ready      = ($urandom_range(0, 4) != 0);
      dispatch_dst_valid  = ($urandom_range(0, 4) != 0);
      dispatch_dst_arf_id = 5'($urandom_range(0, 15));
      dispatch_rob_id     = 3'($urandom_range(0, 7));
      retire              = ($urandom_range(0, 1) != 0);
      retire_arf_id       = 5'($urandom_range(0, 15));
      retire_rob_id       = 3'($urandom_range(0, 7));
      retire_reg_data     = $urandom;
      if (retire && $urandom_range(0, 3) != 0) begin
        int start;
        start = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (m_busy[(start + k) % 32]) begin
            retire_arf_id = 5'((start + k) % 32);
            retire_rob_id = m_tag[(start + k) % 32];
            break;
          end
        end
      end
      retire_redirect_pc_valid = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 199) == 0);
      src1_arf_id = ($urandom_range(0, 2) == 0) ? retire_arf_id : 5'($urandom_range(0, 15));
      src2_arf_id = 5'($urandom_range(0, 31));
      check_lookups("rand");
      tick();
    end
    src1_arf_id = 0; src2_arf_id = 0;
    check_lookups("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
